// File: rtl/sys_exit_if.sv
// Exit request bus: per-source valid/code from requesters, one-hot grant back.
interface sys_exit_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NSRC = 4
);
    logic [NSRC-1:0]      req_valid_i;
    logic [NSRC*XLEN-1:0] req_code_i;
    logic [NSRC-1:0]      req_ready_o;

    // Requesters drive valid/code and observe the grant.
    modport master (
        output req_valid_i,
        output req_code_i,
        input  req_ready_o
    );

    // The exit controller samples requests and drives the grant.
    modport slave (
        input  req_valid_i,
        input  req_code_i,
        output req_ready_o
    );
endinterface

// File: rtl/sys_exit_ctrl.sv
// End-of-run controller: arbitrates exit requests, runs a hang watchdog,
// waits a drain window and then raises a sticky exit flag with its code.
module sys_exit_ctrl #(
    parameter int unsigned    XLEN         = 32,
    parameter int unsigned    NSRC         = 4,
    parameter int unsigned    WDOG_CYCLES  = 20,
    parameter int unsigned    DRAIN_CYCLES = 4,
    parameter logic [XLEN-1:0] TIMEOUT_CODE = XLEN'('hDEAD)
) (
    input  logic                      clk,
    input  logic                      rstn,
    sys_exit_if.slave                 req,
    input  logic                      en_i,
    input  logic                      kick_i,
    output logic                      busy_o,
    output logic                      exit_o,
    output logic [XLEN-1:0]           exit_code_o,
    output logic [$clog2(NSRC+1)-1:0] exit_src_o,
    output logic                      timeout_o
);

    localparam int unsigned SW = $clog2(NSRC + 1);
    // Keep counters at least one bit wide when a feature is disabled.
    localparam int unsigned WW = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam int unsigned DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WDOG_LAST  = WW'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic          WDOG_ON    = (WDOG_CYCLES > 0);
    localparam logic          NO_DRAIN   = (DRAIN_CYCLES == 0);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WW-1:0]     wdog_q, wdog_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [XLEN-1:0]   code_q, code_d;
    logic [SW-1:0]     src_q, src_d;
    logic              timeout_q, timeout_d;

    logic              found;
    logic [NSRC-1:0]   grant;
    logic [SW-1:0]     win_src;
    logic [XLEN-1:0]   win_code;
    logic              decide;

    // Fixed-priority pick of the lowest-indexed valid request.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        win_src  = '0;
        win_code = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (!found && req.req_valid_i[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                win_src  = SW'(i);
                win_code = req.req_code_i[i*XLEN +: XLEN];
            end
        end
    end

    // Grant is only offered while still running.
    always_comb begin
        req.req_ready_o = (state_q == StRun) ? grant : '0;
    end

    // Next-state: arbitration, watchdog and drain window.
    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        drain_d   = drain_q;
        code_d    = code_q;
        src_d     = src_q;
        timeout_d = timeout_q;
        decide    = 1'b0;
        unique case (state_q)
            StRun: begin
                if (found) begin
                    // A request beats a coincident watchdog expiry.
                    decide = 1'b1;
                    code_d = win_code;
                    src_d  = win_src;
                end else if (WDOG_ON && en_i && !kick_i && (wdog_q == WDOG_LAST)) begin
                    decide    = 1'b1;
                    code_d    = TIMEOUT_CODE;
                    src_d     = SW'(NSRC);
                    timeout_d = 1'b1;
                end else if (kick_i) begin
                    wdog_d = '0;
                end else if (WDOG_ON && en_i) begin
                    wdog_d = wdog_q + 1'b1;
                end
                if (decide) begin
                    drain_d = '0;
                    state_d = NO_DRAIN ? StDone : StDrain;
                end
            end
            StDrain: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State and latched exit information.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StRun;
            wdog_q    <= '0;
            drain_q   <= '0;
            code_q    <= '0;
            src_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            drain_q   <= drain_d;
            code_q    <= code_d;
            src_q     <= src_d;
            timeout_q <= timeout_d;
        end
    end

    // Flags decode straight from the state register, so they cannot glitch.
    always_comb begin
        busy_o      = (state_q == StDrain);
        exit_o      = (state_q == StDone);
        exit_code_o = code_q;
        exit_src_o  = src_q;
        timeout_o   = timeout_q;
    end

endmodule

// File: tb/tb_sys_exit_ctrl.sv
// Bench for sys_exit_ctrl: vector table, directed corner sequences,
// a zero-watchdog/zero-drain instance, and randomized runs against a model.
module tb_sys_exit_ctrl;

    localparam int WDOG  = 20;
    localparam int DRAIN = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en, kick, busy, ex, to;
    logic [31:0] code;
    logic [2:0]  src;
    logic        en0, kick0, busy0, ex0, to0;
    logic [31:0] code0;
    logic [2:0]  src0;
    logic        busy0_seen;

    int total = 0;
    int bad   = 0;

    sys_exit_if #(.XLEN(32), .NSRC(4)) rif ();
    sys_exit_if #(.XLEN(32), .NSRC(4)) rif0 ();

    sys_exit_ctrl #(.XLEN(32), .NSRC(4), .WDOG_CYCLES(WDOG), .DRAIN_CYCLES(DRAIN)) u_dut (
        .clk(clk), .rstn(rstn), .req(rif), .en_i(en), .kick_i(kick), .busy_o(busy),
        .exit_o(ex), .exit_code_o(code), .exit_src_o(src), .timeout_o(to)
    );

    sys_exit_ctrl #(.XLEN(32), .NSRC(4), .WDOG_CYCLES(0), .DRAIN_CYCLES(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .req(rif0), .en_i(en0), .kick_i(kick0), .busy_o(busy0),
        .exit_o(ex0), .exit_code_o(code0), .exit_src_o(src0), .timeout_o(to0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy0) busy0_seen = 1'b1;

    typedef struct packed {
        logic [3:0]   valid;
        logic [127:0] codes;
        logic [3:0]   ready;
        logic [2:0]   src;
        logic [31:0]  code;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rif.req_valid_i  = '0;
        rif.req_code_i   = '0;
        rif0.req_valid_i = '0;
        rif0.req_code_i  = '0;
        en = 1'b1; kick = 1'b0; en0 = 1'b1; kick0 = 1'b0;
    endtask

    // Leaves the bench on a falling edge with zero edges seen since release.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Steps until exit_o is seen; n counts edges, continuing from n_start.
    task automatic wait_exit(input int n_start, output int n);
        n = n_start;
        while (!ex && n < 300) begin
            step();
            n++;
        end
    endtask

    // Model state for randomized runs.
    bit          m_dec;
    int          m_dec_edge, m_idle, m_edges;
    logic [31:0] m_code;
    logic [2:0]  m_src;
    logic        m_to;

    initial begin
        int n, busy_n, viol;
        logic [3:0] v, g;
        logic [127:0] cw;
        logic [31:0] hold_code;

        vecs[0] = '{4'b0110, {32'd0, 32'd7, 32'd42, 32'd0}, 4'b0010, 3'd1, 32'd42};
        vecs[1] = '{4'b1000, {32'h0BADF00D, 96'd0}, 4'b1000, 3'd3, 32'h0BADF00D};
        vecs[2] = '{4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b0001, 3'd0, 32'd1};
        vecs[3] = '{4'b1010, {32'hAAAA, 32'd0, 32'hBBBB, 32'd0}, 4'b0010, 3'd1, 32'hBBBB};
        vecs[4] = '{4'b1100, {32'h11, 32'h22, 64'd0}, 4'b0100, 3'd2, 32'h22};

        rstn = 1'b0;
        clear_inputs();
        busy0_seen = 1'b0;

        // Reset values, then watchdog-only run.
        #1;
        chk("rst exit", ex, 0);
        chk("rst busy", busy, 0);
        chk("rst code", code, 0);
        chk("rst src", src, 0);
        chk("rst timeout", to, 0);
        chk("rst ready", rif.req_ready_o, 0);
        do_reset();
        n = 0; busy_n = -1;
        while (!ex && n < 300) begin
            step();
            n++;
            if (busy && busy_n < 0) busy_n = n;
        end
        // n edges after release puts exit_o in one-based cycle n+1.
        chk("t1 exit cycle", n + 1, WDOG + DRAIN + 1);
        chk("t1 busy start edge", busy_n, WDOG);
        chk("t1 code", code, 32'hDEAD);
        chk("t1 src", src, 4);
        chk("t1 timeout", to, 1);
        chk("t1 busy in done", busy, 0);
        // DONE holds whatever arrives.
        viol = 0;
        for (int c = 0; c < 20; c++) begin
            rif.req_valid_i = 4'($urandom_range(0, 15));
            rif.req_code_i  = {$urandom, $urandom, $urandom, $urandom};
            kick = 1'($urandom);
            #1;
            if (rif.req_ready_o != 0) viol++;
            step();
            if (!ex || code != 32'hDEAD || src != 4 || !to || busy) viol++;
        end
        chk("t1 done holds", viol, 0);

        // Arbitration vectors.
        for (int k = 0; k < 5; k++) begin
            do_reset();
            rif.req_valid_i = vecs[k].valid;
            rif.req_code_i  = vecs[k].codes;
            #1;
            chk($sformatf("v%0d ready", k), rif.req_ready_o, vecs[k].ready);
            step();
            rif.req_valid_i = '0;
            chk($sformatf("v%0d busy", k), busy, 1);
            wait_exit(1, n);
            chk($sformatf("v%0d latency", k), n, DRAIN + 1);
            chk($sformatf("v%0d code", k), code, vecs[k].code);
            chk($sformatf("v%0d src", k), src, vecs[k].src);
            chk($sformatf("v%0d timeout", k), to, 0);
        end

        // Regular kicks keep the watchdog away, then source 3 exits with code 0.
        do_reset();
        for (int c = 0; c < 200; c++) begin
            kick = (c % 10 == 9);
            step();
        end
        kick = 1'b0;
        chk("t3 no exit", ex, 0);
        chk("t3 no busy", busy, 0);
        rif.req_valid_i = 4'b1000;
        rif.req_code_i  = '0;
        step();
        rif.req_valid_i = '0;
        wait_exit(1, n);
        chk("t3 latency", n, DRAIN + 1);
        chk("t3 code", code, 0);
        chk("t3 src", src, 3);
        chk("t3 timeout", to, 0);

        // Request coinciding with expiry wins.
        do_reset();
        repeat (WDOG - 1) step();
        rif.req_valid_i = 4'b0001;
        rif.req_code_i  = 128'd1;
        #1;
        chk("t4 ready", rif.req_ready_o, 4'b0001);
        step();
        rif.req_valid_i = '0;
        wait_exit(1, n);
        chk("t4 latency", n, DRAIN + 1);
        chk("t4 code", code, 1);
        chk("t4 src", src, 0);
        chk("t4 timeout", to, 0);

        // Kick on the expiry cycle restarts the count.
        do_reset();
        repeat (WDOG - 1) step();
        kick = 1'b1;
        step();
        kick = 1'b0;
        wait_exit(WDOG, n);
        chk("t4k exit edge", n, 2 * WDOG + DRAIN);
        chk("t4k timeout", to, 1);

        // Frozen count while en_i is low.
        do_reset();
        repeat (5) step();
        en = 1'b0;
        repeat (30) step();
        en = 1'b1;
        wait_exit(35, n);
        chk("t4e exit edge", n, WDOG + DRAIN + 30);

        // Asynchronous reset mid-drain, then a fresh exit.
        do_reset();
        rif.req_valid_i = 4'b0100;
        rif.req_code_i  = {32'd0, 32'h55, 64'd0};
        step();
        rif.req_valid_i = '0;
        step();
        chk("t5 busy mid", busy, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t5 async busy", busy, 0);
        chk("t5 async exit", ex, 0);
        chk("t5 async code", code, 0);
        chk("t5 async src", src, 0);
        @(negedge clk);
        rstn = 1'b1;
        rif.req_valid_i = 4'b0010;
        rif.req_code_i  = {64'd0, 32'd9, 32'd0};
        step();
        rif.req_valid_i = '0;
        wait_exit(1, n);
        chk("t5 latency", n, DRAIN + 1);
        chk("t5 code", code, 9);
        chk("t5 src", src, 1);

        // Zero watchdog, zero drain instance.
        do_reset();
        busy0_seen = 1'b0;
        viol = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (ex0 || to0) viol++;
        end
        chk("t6 no timeout", viol, 0);
        rif0.req_valid_i = 4'b0010;
        rif0.req_code_i  = {64'd0, 32'h77, 32'd0};
        #1;
        chk("t6 ready", rif0.req_ready_o, 4'b0010);
        step();
        rif0.req_valid_i = '0;
        chk("t6 exit next", ex0, 1);
        chk("t6 code", code0, 32'h77);
        chk("t6 src", src0, 1);
        chk("t6 timeout", to0, 0);
        chk("t6 busy never", busy0_seen, 0);

        // Randomized runs against the model.
        for (int t = 0; t < 10; t++) begin
            do_reset();
            m_dec = 0; m_idle = 0; m_edges = 0; m_dec_edge = 0;
            m_code = '0; m_src = '0; m_to = 0;
            for (int c = 0; c < 60; c++) begin
                chk("rnd exit", ex, m_dec && (m_edges - m_dec_edge >= DRAIN));
                chk("rnd busy", busy, m_dec && (m_edges - m_dec_edge < DRAIN));
                chk("rnd code", code, m_code);
                chk("rnd src", src, m_src);
                chk("rnd timeout", to, m_to);
                v  = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                cw = {$urandom, $urandom, $urandom, $urandom};
                rif.req_valid_i = v;
                rif.req_code_i  = cw;
                en   = ($urandom_range(0, 4) != 0);
                kick = ($urandom_range(0, 24) == 0);
                #1;
                g = m_dec ? 4'd0 : (v & (~v + 4'd1));
                chk("rnd ready", rif.req_ready_o, g);
                if (!m_dec) begin
                    if (v != 0) begin
                        m_dec  = 1;
                        m_src  = 3'($clog2(g));
                        m_code = cw[m_src*32 +: 32];
                        m_dec_edge = m_edges + 1;
                    end else if (en && !kick && m_idle + 1 == WDOG) begin
                        m_dec  = 1;
                        m_src  = 3'd4;
                        m_code = 32'hDEAD;
                        m_to   = 1;
                        m_dec_edge = m_edges + 1;
                    end else if (kick) begin
                        m_idle = 0;
                    end else if (en) begin
                        m_idle++;
                    end
                end
                step();
                m_edges++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
